// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
// Scans a FB_W-wide, 8-bit RRRGGGBB framebuffer out as VGA. Each stored pixel
// is shown 2x wide and 2x tall, and each channel is widened to 8 bits.
// Datapath: raster counters -> stage 1 (read address, sync, visible)
//           -> stage 2 (colour expand, registered pins).
// Every stage moves only on the pixel tick, so pins are stable for a whole
// pixel period and all outputs trail the counters by exactly two pixels.

module framebuffer_scanout #(
    parameter int CLK_DIV = 2,    // system clocks per pixel, must be >= 2
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int FB_W    = 320
) (
    input  logic        clock,
    input  logic        reset,
    output logic [16:0] rdaddress,
    input  logic [7:0]  q,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);

    localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS_END = H_W'(H_VIS);
    localparam logic [H_W-1:0]   HS_BEGIN  = H_W'(H_VIS + H_FP);
    localparam logic [H_W-1:0]   HS_END    = H_W'(H_VIS + H_FP + H_SYNC);

    localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_VIS_END = V_W'(V_VIS);
    localparam logic [V_W-1:0]   VS_BEGIN  = V_W'(V_VIS + V_FP);
    localparam logic [V_W-1:0]   VS_END    = V_W'(V_VIS + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q,     div_d;
    logic [H_W-1:0]   h_cnt_q,   h_cnt_d;
    logic [V_W-1:0]   v_cnt_q,   v_cnt_d;
    logic             fs_q,      fs_d;

    logic [16:0]      s1_addr_q, s1_addr_d;
    logic             s1_vis_q,  s1_vis_d;
    logic             s1_hs_q,   s1_hs_d;
    logic             s1_vs_q,   s1_vs_d;

    logic [7:0]       s2_r_q,    s2_r_d;
    logic [7:0]       s2_g_q,    s2_g_d;
    logic [7:0]       s2_b_q,    s2_b_d;
    logic             s2_hs_q,   s2_hs_d;
    logic             s2_vs_q,   s2_vs_d;
    logic             s2_blank_q, s2_blank_d;

    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             raster_vis;
    logic [16:0]      row_base;
    logic [16:0]      col_off;

    assign tick   = (div_q == DIV_LAST);
    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    // ------------------------------------------------------------------
    // Framebuffer address: each stored row/column covers two screen
    // lines/pixels, so both raster coordinates are halved first.
    // ------------------------------------------------------------------
    assign col_off = 17'(h_cnt_q >> 1);

    generate
        if (FB_W == 320) begin : g_row_shift_add
            logic [16:0] row_y;
            assign row_y    = 17'(v_cnt_q >> 1);
            // y*320 = y*256 + y*64, two shifted copies and one adder
            assign row_base = (row_y << 8) + (row_y << 6);
        end else begin : g_row_mult
            logic [16:0] row_y;
            assign row_y    = 17'(v_cnt_q >> 1);
            assign row_base = row_y * 17'(FB_W);
        end
    endgenerate

    assign raster_vis = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);

    // Pixel divider and raster counters; frame_start flags the wrap to (0,0).
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold it.
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        fs_d    = 1'b0;
        if (tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d = '0;
                    fs_d    = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + V_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + H_W'(1);
            end
        end
    end

    // Stage 1: read address plus raw sync/visible flags for this pixel.
    always_comb begin
        s1_addr_d = s1_addr_q;
        s1_vis_d  = s1_vis_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        if (tick) begin
            s1_vis_d  = raster_vis;
            s1_addr_d = raster_vis ? (row_base + col_off) : '0;
            s1_hs_d   = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
            s1_vs_d   = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
        end
    end

    // Stage 2: capture the returned pixel, expand it, align sync with it.
    always_comb begin
        s2_r_d     = s2_r_q;
        s2_g_d     = s2_g_q;
        s2_b_d     = s2_b_q;
        s2_hs_d    = s2_hs_q;
        s2_vs_d    = s2_vs_q;
        s2_blank_d = s2_blank_q;
        if (tick) begin
            s2_hs_d    = s1_hs_q;
            s2_vs_d    = s1_vs_q;
            s2_blank_d = s1_vis_q;
            if (s1_vis_q) begin
                // bit replication maps the channel's full scale onto 0..255
                s2_r_d = {q[7:5], q[7:5], q[7:6]};
                s2_g_d = {q[4:2], q[4:2], q[4:3]};
                s2_b_d = {q[1:0], q[1:0], q[1:0], q[1:0]};
            end else begin
                s2_r_d = '0;
                s2_g_d = '0;
                s2_b_d = '0;
            end
        end
    end

    // Divider, counters and frame pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of code order.
        if (reset) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fs_q    <= fs_d;
        end
    end

    // Stage 1 registers; syncs idle high out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_addr_q <= '0;
            s1_vis_q  <= 1'b0;
            s1_hs_q   <= 1'b1;
            s1_vs_q   <= 1'b1;
        end else begin
            s1_addr_q <= s1_addr_d;
            s1_vis_q  <= s1_vis_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
        end
    end

    // Stage 2 registers drive the VGA pins directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_r_q     <= '0;
            s2_g_q     <= '0;
            s2_b_q     <= '0;
            s2_hs_q    <= 1'b1;
            s2_vs_q    <= 1'b1;
            s2_blank_q <= 1'b0;
        end else begin
            s2_r_q     <= s2_r_d;
            s2_g_q     <= s2_g_d;
            s2_b_q     <= s2_b_d;
            s2_hs_q    <= s2_hs_d;
            s2_vs_q    <= s2_vs_d;
            s2_blank_q <= s2_blank_d;
        end
    end

    assign rdaddress   = s1_addr_q;
    assign vga_r       = s2_r_q;
    assign vga_g       = s2_g_q;
    assign vga_b       = s2_b_q;
    assign vga_hs      = s2_hs_q;
    assign vga_vs      = s2_vs_q;
    assign vga_blank_n = s2_blank_q;
    assign vga_sync_n  = 1'b0;
    // pixel clock is high for the first half of each divider period
    assign vga_clk     = (div_q < DIV_HALF);
    assign frame_start = fs_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
`timescale 1ns/1ps
// Bench for framebuffer_scanout. Default horizontal timing (so the 320-wide
// shift-add row path is used) with a short vertical raster to keep frames
// small. Expected values come from a pixel-index model: after e clocks since
// reset release, e/CLK_DIV ticks have happened, stage 1 shows pixel T-1 and
// the pins show pixel T-2.

module tb_framebuffer_scanout;

    localparam int CLK_DIV = 2;
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 6;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 1;
    localparam int FB_W    = 320;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [16:0] rdaddress;
    logic [7:0]  q;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

    int vectors     = 0;
    int miscompares = 0;
    int e;                       // clocks since reset release

    logic [7:0] fb [0:1023];

    framebuffer_scanout #(
        .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .FB_W(FB_W)
    ) dut (
        .clock(clock), .reset(reset), .rdaddress(rdaddress), .q(q),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_clk(vga_clk), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Synchronous-read framebuffer: q follows rdaddress one clock later.
    always @(posedge clock) q <= fb[rdaddress[9:0]];

    always @(posedge clock or posedge reset) begin
        if (reset) e <= 0;
        else       e <= e + 1;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int hpos(int p); return p % H_TOTAL; endfunction
    function automatic int vpos(int p); return (p / H_TOTAL) % V_TOTAL; endfunction
    function automatic bit is_vis(int p);
        return (hpos(p) < H_VIS) && (vpos(p) < V_VIS);
    endfunction
    function automatic int fb_addr(int p);
        return is_vis(p) ? (vpos(p) / 2) * FB_W + hpos(p) / 2 : 0;
    endfunction
    function automatic logic [23:0] expand(int c);
        int r3, g3, b2, r, g, b;
        r3 = (c >> 5) & 7;
        g3 = (c >> 2) & 7;
        b2 = c & 3;
        r  = r3 * 32 + r3 * 4 + r3 / 2;
        g  = g3 * 32 + g3 * 4 + g3 / 2;
        b  = b2 * 85;
        return {8'(r), 8'(g), 8'(b)};
    endfunction
    function automatic int exp_addr(int ee);
        return (ee / CLK_DIV >= 1) ? fb_addr(ee / CLK_DIV - 1) : 0;
    endfunction
    function automatic logic [23:0] exp_rgb(int ee);
        int t = ee / CLK_DIV;
        if (t < 2 || !is_vis(t - 2)) return 24'h0;
        return expand(int'(fb[fb_addr(t - 2)]));
    endfunction
    function automatic logic exp_hs(int ee);
        int t = ee / CLK_DIV;
        if (t < 2) return 1'b1;
        return !((hpos(t - 2) >= H_VIS + H_FP) && (hpos(t - 2) < H_VIS + H_FP + H_SYNC));
    endfunction
    function automatic logic exp_vs(int ee);
        int t = ee / CLK_DIV;
        if (t < 2) return 1'b1;
        return !((vpos(t - 2) >= V_VIS + V_FP) && (vpos(t - 2) < V_VIS + V_FP + V_SYNC));
    endfunction
    function automatic logic exp_blank(int ee);
        return (ee / CLK_DIV >= 2) && is_vis(ee / CLK_DIV - 2);
    endfunction
    function automatic logic exp_fs(int ee);
        return (ee > 0) && (ee % CLK_DIV == 0) && ((ee / CLK_DIV) % FRAME == 0);
    endfunction
    function automatic logic exp_vclk(int ee);
        return (ee % CLK_DIV) < (CLK_DIV / 2);
    endfunction

    // Advance one clock and return at the falling edge for sampling.
    task automatic next_clk();
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom);
        fb[0] = 8'hE0; fb[1] = 8'h1C; fb[2] = 8'h03; fb[3] = 8'h92;
        #1 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next_clk();
            vectors++;
            if ({vga_r, vga_g, vga_b} !== 24'h0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 ||
                vga_blank_n !== 1'b0 || rdaddress !== 17'd0 || frame_start !== 1'b0 ||
                vga_sync_n !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state clk=%0d got rgb=%h hs=%b vs=%b blank_n=%b addr=%0d fs=%b sync_n=%b exp rgb=0 hs=1 vs=1 blank_n=0 addr=0 fs=0 sync_n=0",
                         c, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, rdaddress, frame_start, vga_sync_n);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_addressing();
        int sp_h [8] = '{0, 1, 2, 3, 700, 5, 639, 100};
        int sp_v [8] = '{0, 0, 0, 0, 0, 3, 5, 7};
        int sp_a [8] = '{0, 0, 1, 1, 0, 322, 959, 0};
        int t;
        while (e / CLK_DIV < 5702) begin
            next_clk();
            t = e / CLK_DIV;
            vectors++;
            if (rdaddress !== 17'(exp_addr(e))) begin
                miscompares++;
                $display("FAIL rdaddress e=%0d got %0d exp %0d", e, rdaddress, exp_addr(e));
            end
            if (t >= 1 && e % CLK_DIV == 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (t - 1 == sp_v[k] * H_TOTAL + sp_h[k]) begin
                        vectors++;
                        if (rdaddress !== 17'(sp_a[k])) begin
                            miscompares++;
                            $display("FAIL addr_spot h=%0d v=%0d got %0d exp %0d",
                                     sp_h[k], sp_v[k], rdaddress, sp_a[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_colour();
        logic [23:0] col_exp [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA};
        int t;
        while (e / CLK_DIV < FRAME + 10) begin
            next_clk();
            t = e / CLK_DIV;
            vectors++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(e) || vga_blank_n !== exp_blank(e)) begin
                miscompares++;
                $display("FAIL colour e=%0d got rgb=%h blank_n=%b exp rgb=%h blank_n=%b",
                         e, {vga_r, vga_g, vga_b}, vga_blank_n, exp_rgb(e), exp_blank(e));
            end
            vectors++;
            if (frame_start !== exp_fs(e)) begin
                miscompares++;
                $display("FAIL first_frame_start e=%0d got %b exp %b", e, frame_start, exp_fs(e));
            end
            if (e % CLK_DIV == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (t - 2 == FRAME + 2 * k) begin
                        vectors++;
                        if ({vga_r, vga_g, vga_b} !== col_exp[k]) begin
                            miscompares++;
                            $display("FAIL colour_spot fb[%0d] got %h exp %h",
                                     k, {vga_r, vga_g, vga_b}, col_exp[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        int starts [2] = '{2 * FRAME - 3, 2 * FRAME + 2 * H_TOTAL - 3};
        int fs_seen;
        for (int w = 0; w < 2; w++) begin
            while (e / CLK_DIV < starts[w]) next_clk();
            fs_seen = 0;
            for (int c = 0; c < 8 * CLK_DIV; c++) begin
                next_clk();
                fs_seen += int'(frame_start);
                vectors++;
                if (frame_start !== exp_fs(e) || vga_hs !== exp_hs(e) || vga_vs !== exp_vs(e) ||
                    rdaddress !== 17'(exp_addr(e)) || {vga_r, vga_g, vga_b} !== exp_rgb(e) ||
                    vga_clk !== exp_vclk(e)) begin
                    miscompares++;
                    $display("FAIL wrap e=%0d got fs=%b hs=%b vs=%b addr=%0d rgb=%h vclk=%b exp fs=%b hs=%b vs=%b addr=%0d rgb=%h vclk=%b",
                             e, frame_start, vga_hs, vga_vs, rdaddress, {vga_r, vga_g, vga_b}, vga_clk,
                             exp_fs(e), exp_hs(e), exp_vs(e), exp_addr(e), exp_rgb(e), exp_vclk(e));
                end
            end
            vectors++;
            if (fs_seen != ((w == 0) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL wrap_pulse_count window=%0d got %0d exp %0d", w, fs_seen, (w == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_sync_timing();
        int hs_low = 0, vs_low = 0, blank_hi = 0, vclk_hi = 0, fs_cnt = 0;
        int run = 0, max_run = 0;
        for (int c = 0; c < FRAME * CLK_DIV; c++) begin
            next_clk();
            hs_low   += int'(!vga_hs);
            vs_low   += int'(!vga_vs);
            blank_hi += int'(vga_blank_n);
            vclk_hi  += int'(vga_clk);
            fs_cnt   += int'(frame_start);
            run       = vga_hs ? 0 : run + 1;
            if (run > max_run) max_run = run;
        end
        vectors++;
        if (hs_low != V_TOTAL * H_SYNC * CLK_DIV) begin
            miscompares++;
            $display("FAIL hs_low_clocks got %0d exp %0d", hs_low, V_TOTAL * H_SYNC * CLK_DIV);
        end
        vectors++;
        if (max_run != H_SYNC * CLK_DIV) begin
            miscompares++;
            $display("FAIL hs_pulse_width got %0d exp %0d", max_run, H_SYNC * CLK_DIV);
        end
        vectors++;
        if (vs_low != V_SYNC * H_TOTAL * CLK_DIV) begin
            miscompares++;
            $display("FAIL vs_low_clocks got %0d exp %0d", vs_low, V_SYNC * H_TOTAL * CLK_DIV);
        end
        vectors++;
        if (blank_hi != V_VIS * H_VIS * CLK_DIV) begin
            miscompares++;
            $display("FAIL blank_n_high_clocks got %0d exp %0d", blank_hi, V_VIS * H_VIS * CLK_DIV);
        end
        vectors++;
        if (vclk_hi != FRAME * (CLK_DIV / 2)) begin
            miscompares++;
            $display("FAIL vga_clk_high_clocks got %0d exp %0d", vclk_hi, FRAME * (CLK_DIV / 2));
        end
        vectors++;
        if (fs_cnt != 1) begin
            miscompares++;
            $display("FAIL frame_start_per_frame got %0d exp 1", fs_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int target = 3 * FRAME + 3 * H_TOTAL + 300;
        int pulses = 0, pulse_e = -1;
        while (e / CLK_DIV < target) next_clk();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({vga_r, vga_g, vga_b} !== 24'h0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 ||
            vga_blank_n !== 1'b0 || rdaddress !== 17'd0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got rgb=%h hs=%b vs=%b blank_n=%b addr=%0d fs=%b exp rgb=0 hs=1 vs=1 blank_n=0 addr=0 fs=0",
                     {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, rdaddress, frame_start);
        end
        for (int c = 0; c < 3; c++) next_clk();
        reset = 1'b0;
        for (int c = 0; c < FRAME * CLK_DIV + 2 * CLK_DIV; c++) begin
            next_clk();
            if (frame_start === 1'b1) begin
                pulses++;
                pulse_e = e;
            end
            vectors++;
            if (frame_start !== exp_fs(e) || rdaddress !== 17'(exp_addr(e)) ||
                vga_hs !== exp_hs(e) || vga_vs !== exp_vs(e)) begin
                miscompares++;
                $display("FAIL restart e=%0d got fs=%b addr=%0d hs=%b vs=%b exp fs=%b addr=%0d hs=%b vs=%b",
                         e, frame_start, rdaddress, vga_hs, vga_vs,
                         exp_fs(e), exp_addr(e), exp_hs(e), exp_vs(e));
            end
        end
        vectors++;
        if (pulses != 1 || pulse_e != FRAME * CLK_DIV) begin
            miscompares++;
            $display("FAIL restart_frame_start got count=%0d at=%0d exp count=1 at=%0d",
                     pulses, pulse_e, FRAME * CLK_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_colour();
        test_wrap();
        test_sync_timing();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Downstream consumer of the 320x240, 8-bit-colour dual-port framebuffer.
- Generates 640x480@60 VGA timing from the system clock.
- Drives the framebuffer read port (rdaddress), takes the returned pixel (q), and doubles each pixel 2x horizontally and vertically.
- Expands RRRGGGBB colour to 8-bit-per-channel outputs for the VGA DAC, and emits a frame-start pulse so upstream writers can sync screen swaps.

Parameters:
- CLK_DIV, 2, system clocks per pixel; must be >= 2. Default gives 25 MHz pixel rate from a 50 MHz clock.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- FB_W, 320, framebuffer row width in pixels.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rdaddress  output  17  framebuffer read address.
- q  input  8  framebuffer read data, RRRGGGBB; valid one clock after rdaddress changes.
- vga_r  output  8  red channel.
- vga_g  output  8  green channel.
- vga_b  output  8  blue channel.
- vga_hs  output  1  horizontal sync, active-low.
- vga_vs  output  1  vertical sync, active-low.
- vga_blank_n  output  1  high during the visible region.
- vga_sync_n  output  1  constant 0.
- vga_clk  output  1  pixel clock: high for the first CLK_DIV/2 clocks of each pixel period.
- frame_start  output  1  one-clock pulse at the start of each frame.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and on release:
  - h_cnt, v_cnt and the clock divider are 0.
  - rdaddress = 0; vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; vga_blank_n = 0; frame_start = 0.
- Reset mid-frame aborts the frame. The first tick after release restarts at (0,0) with no frame_start for the aborted frame.
- Pixel tick: the divider counts 0..CLK_DIV-1; tick is asserted when the divider = CLK_DIV-1. All pipeline stages advance only on tick.
- Counters:
  - h_cnt: 0..H_TOTAL-1, where H_TOTAL = 800 at default parameters.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt: 0..V_TOTAL-1, where V_TOTAL = 525 at default parameters; wraps to 0 after V_TOTAL-1.
- Stage 1 (tick, from counters):
  - visible = (h_cnt < H_VIS) and (v_cnt < V_VIS).
  - If visible: rdaddress = (v_cnt>>1)*FB_W + (h_cnt>>1). Otherwise rdaddress = 0.
  - Maximum address at default parameters is 76799; no overflow of 17 bits.
  - Multiply implemented as shift-add, (y<<8)+(y<<6), when FB_W = 320.
  - Also register into stage 1: visible, hs_raw = !(H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC), vs_raw likewise for the vertical counter.
- Stage 2 (next tick):
  - Capture q, which has been stable since one clock after stage 1.
  - vga_r = {q[7:5], q[7:5], q[7:6]}.
  - vga_g = {q[4:2], q[4:2], q[4:3]}.
  - vga_b = {q[1:0], q[1:0], q[1:0], q[1:0]}.
  - If stage-1 visible = 0, force rgb = 0.
  - vga_hs, vga_vs and vga_blank_n are the stage-1 values, so all outputs are aligned.
- Total latency: counter value to VGA pins = 2 pixel ticks. Sync pulses are shifted by the same 2 pixels, which is within porch margins.
- frame_start: high for exactly one clock, on the clock edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Colour output never changes mid-pixel; it updates only on tick.
- vga_sync_n is constant 0.

Test Plan:
- Reset/idle: assert reset for 5 clocks, then release -> during reset rgb = 0, hs = vs = 1, blank_n = 0, rdaddress = 0; first frame_start occurs 800*525*2 = 840000 clocks after release.
- Addressing: observe rdaddress at visible pixel h = 0..3 and y line 0 -> 0,0,1,1. At line v = 3, h = 5 -> 322. At h = 639, v = 479 -> 76799. During blanking -> 0.
- Colour expand: model returns q = addr[7:0] one clock late; q = 8'hE0 -> r = FF, g = 00, b = 00; q = 8'h1C -> g = FF; q = 8'h03 -> b = FF; q = 8'h92 -> r = 92, g = 92, b = AA. All colours appear 2 ticks after the corresponding counter value.
- Sync timing: measure over one frame -> hs low for 96 pixels (192 clocks) per 800-pixel line; vs low for 2 lines; blank_n high for 640 pixels per line on 480 lines; 60 frames = 50.4 M clocks.
- Reset mid-frame: assert reset at v = 200, h = 300 for 3 clocks -> outputs return to reset values immediately (asynchronously); timing restarts at (0,0); next frame_start 840000 clocks after release.
- Wrap boundary: check the line-end/frame-end transition -> h = 799 to 0 increments v; (799,524) to (0,0) produces a single one-clock frame_start; no missing or duplicated pixel at the wrap.
